// File: rtl/rx_buffer_ctrl.sv
// UART receive buffer: acks each Receive pulse once, queues {parity, byte} in a show-ahead FIFO.
// Push lands on the edge leaving WAIT, visible next cycle; a full FIFO drops bytes (counted) and never stalls the receiver.
module rx_buffer_ctrl #(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          Receive,
    output logic          Received,
    input  logic [7:0]    Din,
    input  logic          parityErrIn,
    input  logic          rdEn,
    output logic [7:0]    Dout,
    output logic          dataErr,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic [7:0]    dropCount,
    input  logic          clrOverflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        WAIT = 1'b0,
        ACK  = 1'b1
    } state_t;

    typedef struct packed {
        logic       perr;
        logic [7:0] dat;
    } entry_t;

    state_t          state_q, state_d;
    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q;
    logic            push_try, push_ok, pop_ok, drop;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state_q <= WAIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        push_try = 1'b0;
        case (state_q)
            WAIT: begin
                if (Receive) begin
                    push_try = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK: begin
                if (!Receive) state_d = WAIT;
            end
            default: state_d = WAIT;
        endcase
    end

    assign Received = (state_q == ACK);

    // count alone decides full/empty; a pop while full makes room for the push.
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_ok  = rdEn && !empty;
    assign push_ok = push_try && (!full || pop_ok);
    assign drop    = push_try && full && !pop_ok;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= '{perr: parityErrIn, dat: Din};
    end

    assign head    = mem[rd_ptr];
    assign Dout    = head.dat;
    assign dataErr = head.perr;
    assign count   = count_q;

    // A drop in the same cycle as a clear wins: it is the first event after the clear.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            overflow  <= 1'b0;
            dropCount <= '0;
        end else if (clrOverflow) begin
            overflow  <= drop;
            dropCount <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
        end
    end

endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// Directed bench for rx_buffer_ctrl: handshake, FIFO order, overflow, simultaneous push/pop, async reset.
module tb_rx_buffer_ctrl;

    localparam int CW = 4;

    logic          clk;
    logic          Reset;
    logic          Receive;
    logic          Received;
    logic [7:0]    Din;
    logic          parityErrIn;
    logic          rdEn;
    logic [7:0]    Dout;
    logic          dataErr;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic [7:0]    dropCount;
    logic          clrOverflow;

    int n_checks = 0;
    int n_errors = 0;

    rx_buffer_ctrl #(.DEPTH(8)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .Receive     (Receive),
        .Received    (Received),
        .Din         (Din),
        .parityErrIn (parityErrIn),
        .rdEn        (rdEn),
        .Dout        (Dout),
        .dataErr     (dataErr),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overflow    (overflow),
        .dropCount   (dropCount),
        .clrOverflow (clrOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One Receive pulse of one cycle; returns at a negedge with the FSM back in WAIT.
    task automatic push_byte(input logic [7:0] d, input logic perr, input logic pop);
        @(negedge clk);
        Din = d; parityErrIn = perr; Receive = 1'b1; rdEn = pop;
        @(negedge clk);
        Receive = 1'b0; rdEn = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] d);
        @(negedge clk);
        chk(tag, 32'(Dout), 32'(d));
        rdEn = 1'b1;
        @(negedge clk);
        rdEn = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Receive = 1'b0; Din = '0; parityErrIn = 1'b0;
        rdEn = 1'b0; clrOverflow = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_received",  32'(Received),  32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_empty",     32'(empty),     32'd1);
        chk("rst_full",      32'(full),      32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_dropcount", 32'(dropCount), 32'd0);
        Reset = 1'b0;

        // Single pulse, byte visible the cycle after the write edge.
        @(negedge clk);
        Din = 8'hA5; parityErrIn = 1'b0; Receive = 1'b1;
        @(negedge clk);
        Receive = 1'b0;
        chk("t1_received", 32'(Received), 32'd1);
        chk("t1_empty",    32'(empty),    32'd0);
        chk("t1_dout",     32'(Dout),     32'hA5);
        chk("t1_dataerr",  32'(dataErr),  32'd0);
        chk("t1_count",    32'(count),    32'd1);
        @(negedge clk);
        chk("t1_ack_drop", 32'(Received), 32'd0);
        pop_expect("t1_pop", 8'hA5);

        // Long pulse counts once.
        @(negedge clk);
        Din = 8'h3C; Receive = 1'b1;
        repeat (5) @(negedge clk);
        Receive = 1'b0;
        @(negedge clk);
        chk("t2_count", 32'(count), 32'd1);
        chk("t2_dout",  32'(Dout),  32'h3C);
        pop_expect("t2_pop", 8'h3C);
        @(negedge clk);
        chk("t2_empty", 32'(empty), 32'd1);

        // Fill, overflow, drain in order.
        for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b0, 1'b0);
        chk("t3_full",      32'(full),     32'd1);
        chk("t3_count",     32'(count),    32'd8);
        chk("t3_ovf_pre",   32'(overflow), 32'd0);
        push_byte(8'h09, 1'b0, 1'b0);
        chk("t3_overflow",  32'(overflow),  32'd1);
        chk("t3_dropcount", 32'(dropCount), 32'd1);
        chk("t3_count_drp", 32'(count),     32'd8);
        for (int i = 1; i <= 8; i++) pop_expect("t3_pop", 8'(i));
        @(negedge clk);
        chk("t3_empty", 32'(empty), 32'd1);

        @(negedge clk);
        clrOverflow = 1'b1;
        @(negedge clk);
        clrOverflow = 1'b0;
        chk("clr_overflow",  32'(overflow),  32'd0);
        chk("clr_dropcount", 32'(dropCount), 32'd0);

        // Full with simultaneous pop: push accepted, no drop.
        for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i), 1'b0, 1'b0);
        push_byte(8'h55, 1'b0, 1'b1);
        chk("t4_count",    32'(count),     32'd8);
        chk("t4_overflow", 32'(overflow),  32'd0);
        chk("t4_dropcnt",  32'(dropCount), 32'd0);
        for (int i = 1; i < 8; i++) pop_expect("t4_pop", 8'(8'h10 + i));
        pop_expect("t4_last", 8'h55);
        @(negedge clk);
        chk("t4_empty", 32'(empty), 32'd1);

        // Parity flag travels with the byte; pop on empty ignored.
        push_byte(8'h7E, 1'b1, 1'b0);
        chk("t5_dout",    32'(Dout),    32'h7E);
        chk("t5_dataerr", 32'(dataErr), 32'd1);
        pop_expect("t5_pop", 8'h7E);
        @(negedge clk);
        rdEn = 1'b1;
        repeat (2) @(negedge clk);
        rdEn = 1'b0;
        chk("t5_empty_pop_cnt", 32'(count), 32'd0);
        chk("t5_empty_pop_emp", 32'(empty), 32'd1);
        push_byte(8'h42, 1'b0, 1'b1);
        chk("t5_push_empty_rd_cnt",  32'(count), 32'd1);
        chk("t5_push_empty_rd_dout", 32'(Dout),  32'h42);
        pop_expect("t5_pop42", 8'h42);

        // Async reset while in ACK with three entries.
        push_byte(8'hB1, 1'b0, 1'b0);
        push_byte(8'hB2, 1'b0, 1'b0);
        @(negedge clk);
        Din = 8'hB3; Receive = 1'b1;
        @(negedge clk);
        chk("t6_in_ack",  32'(Received), 32'd1);
        chk("t6_count3",  32'(count),    32'd3);
        #2 Reset = 1'b1;
        #1;
        chk("t6_rst_received", 32'(Received), 32'd0);
        chk("t6_rst_count",    32'(count),    32'd0);
        chk("t6_rst_empty",    32'(empty),    32'd1);
        Receive = 1'b0;
        @(negedge clk);
        Reset = 1'b0;

        // Drop coinciding with clear leaves exactly one recorded drop.
        for (int i = 0; i < 8; i++) push_byte(8'(8'h20 + i), 1'b0, 1'b0);
        push_byte(8'hEE, 1'b0, 1'b0);
        push_byte(8'hEE, 1'b0, 1'b0);
        chk("t6_drop2", 32'(dropCount), 32'd2);
        @(negedge clk);
        Din = 8'hEF; Receive = 1'b1; clrOverflow = 1'b1;
        @(negedge clk);
        Receive = 1'b0; clrOverflow = 1'b0;
        chk("t6_clr_drop_ovf", 32'(overflow),  32'd1);
        chk("t6_clr_drop_cnt", 32'(dropCount), 32'd1);
        chk("t6_clr_drop_fifo", 32'(count),    32'd8);

        // Drop counter saturates.
        for (int i = 0; i < 260; i++) push_byte(8'hFF, 1'b0, 1'b0);
        chk("sat_dropcount", 32'(dropCount), 32'd255);
        chk("sat_overflow",  32'(overflow),  32'd1);
        @(negedge clk);
        clrOverflow = 1'b1;
        @(negedge clk);
        clrOverflow = 1'b0;
        chk("sat_clr", 32'(dropCount), 32'd0);
        pop_expect("sat_head", 8'h20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
